uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
UART receive stage: oversamples the asynchronous serial line, recovers 8N1 frames LSB-first and presents each byte with a one-cycle rx_done strobe. Sits directly upstream of the command decoder: rx_data drives cmd_in, rx_done drives valid. Also flags malformed frames so upper layers can count errors.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency
BAUD, 115200, line rate
CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (integer divide, 434 at defaults), clocks per bit; must be >= 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_in  in  1  raw serial line, asynchronous, idle high
rx_data  out  8  last correctly received byte
rx_done  out  1  one-cycle pulse, rx_data valid
frame_err  out  1  one-cycle pulse, stop bit sampled low
parity_err  out  1  one-cycle pulse, parity mismatch (tied 0 when the optional feature is out)
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values: rx_data=8'h00, rx_done=0, frame_err=0, parity_err=0, busy=0, state=IDLE, both sync flops=1, counters=0.
- rx_in passes through a 2-flop synchronizer (rx_s) before any use. Reset forces both flops to 1 so no false start is seen.
- Bit counter clk_cnt counts 0..CLKS_PER_BIT-1. Bit index bit_idx counts 0..7.
- States:
  - IDLE: on rx_s==0, go to START with clk_cnt=0.
  - START: at clk_cnt==CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with clk_cnt=0 and bit_idx=0. If 1 (glitch), go to IDLE with no pulse.
  - DATA: at clk_cnt==CLKS_PER_BIT-1, shift rx_s into shift[bit_idx] (LSB first) and reset clk_cnt. After bit_idx==7, go to STOP (or PARITY when the feature is in); otherwise increment bit_idx.
  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample. If 1, load rx_data<=shift, pulse rx_done on the next cycle, go to IDLE. If 0, pulse frame_err, leave rx_data unchanged, go to RECOVER.
  - RECOVER: wait for rx_s==1 (handles break or continuous low), then go to IDLE. No pulses are issued in this state.
- rx_done/rx_data timing: rx_done rises in the same cycle rx_data takes its new value. rx_data then holds until the next good frame.
- Back-to-back frames: a start edge in the cycle immediately after STOP→IDLE must be accepted. No idle gap is required beyond the stop bit.
- Pulse exclusivity: rx_done, frame_err and parity_err are mutually exclusive and never exceed 1 cycle.
- Latency: rx_done is asserted 2 (sync) + 9.5·CLKS_PER_BIT + 1 clocks after the start falling edge on rx_in, ±1 clk for edge-phase uncertainty.
- Reset mid-frame: abort immediately to IDLE with no pulse. The partial byte is discarded.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state follows DATA and samples the parity bit after one full bit time. Even parity is required (XOR of 8 data bits plus parity bit == 0).
  - Mismatch: pulse parity_err, leave rx_data unchanged, then still pass through STOP to consume the stop bit. A stop error in the same frame reports parity_err only.
  - Latency grows by CLKS_PER_BIT.
- Undefined: the frame is 8N1, the PARITY state does not exist, and parity_err is constant 0.

Decomposition:
- Package uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP, RECOVER as 3-bit codes), UART_IDLE_LEVEL=1'b1, DATA_BITS=8.
- Sub-module uart_sync2: generic 2-flop synchronizer with a parameterised reset value. It is reused by the TX side for its handshakes.

Test Plan:
Benches use CLK_FREQ_HZ=1000000 and BAUD=100000, so CLKS_PER_BIT=10.
1. Send 8'hA1 in 8N1 → exactly one rx_done pulse, rx_data=8'hA1, frame_err=0, rx_done at 98±1 clks after the start edge.
2. Send 8'hB1 then 8'h55 back-to-back with no idle gap → two rx_done pulses 100 clks apart, values B1 then 55.
3. Low glitch of 3 clks on an idle line → state returns to IDLE, no pulses, rx_data unchanged.
4. Send 8'hC1 with the stop bit forced low, then hold the line low for 30 clks → one frame_err pulse, no rx_done, rx_data keeps its prior value, busy stays high until the line returns high.
5. Assert rst during bit 4 of 8'hA2, release, then send 8'hA2 → no pulse from the aborted frame, one rx_done with 8'hA2 afterwards.
6. With UART_RX_PARITY_EN defined, send 8'h03 with parity=1 (wrong) → one parity_err pulse, no rx_done. Resend with parity=0 → rx_done, rx_data=8'h03.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, line idle level, frame width
// and the even-parity helper used by the receive stage.
package uart_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] RECOVER = 3'd5;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    // High when data plus received parity bit do not give even parity.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
// RST_VAL selects the level both flops take on reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state: shift the input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, reset to the configured level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: oversamples rx_in, recovers LSB-first frames, strobes
// rx_done with each good byte and flags framing errors.
// Macro UART_RX_PARITY_EN: when defined, frames are 8E1 and parity_err is
// live; when undefined, frames are 8N1 and parity_err is tied low.
// CLKS_PER_BIT must be at least 4 so the half-bit start check is meaningful.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic [2:0]           state_q,   state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 par_err_q, par_err_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_blocked;

    uart_sync2 #(
        .RST_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    // A frame with bad parity has already reported; its stop bit is only consumed.
    assign stop_blocked = par_bad_q;
`else
    assign stop_blocked = 1'b0;
`endif

    // Frame FSM: start validation, data shifting, parity/stop sampling.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        par_bad_d   = par_bad_q;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                par_bad_d = 1'b0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    par_bad_d = parity_bad(shift_q, rx_s);
                    par_err_d = parity_bad(shift_q, rx_s);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (stop_blocked) begin
                        state_d = rx_s ? IDLE : RECOVER;
                    end else if (rx_s) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RECOVER;
                    end
                end
            end
            RECOVER: begin
                clk_cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, counters, data and pulse registers; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            par_bad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            par_bad_q   <= par_bad_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = par_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at CLKS_PER_BIT=10.
module tb_uart_rx_frame;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT = 2 + (NBITS - 1) * CPB + CPB / 2 + 1;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int cyc      = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int ovl_cnt  = 0;
    int long_cnt = 0;
    logic       prev_any = 1'b0;
    logic [7:0] d_data [0:63];
    int         d_cyc  [0:63];

    uart_rx_frame #(
        .CLK_FREQ_HZ (1000000),
        .BAUD        (100000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_done) begin
            if (done_cnt < 64) begin
                d_data[done_cnt] = rx_data;
                d_cyc[done_cnt]  = cyc;
            end
            done_cnt = done_cnt + 1;
        end
        if (frame_err)  ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) ovl_cnt = ovl_cnt + 1;
        if (prev_any && (rx_done || frame_err || parity_err)) long_cnt = long_cnt + 1;
        prev_any = rx_done || frame_err || parity_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; stops early after max_cyc clocks; returns the start cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input int max_cyc,
                              output int start_cyc);
        logic [10:0] line;
        int n;
        line = '1;
        line[0] = 1'b0;
        line[8:1] = d;
`ifdef UART_RX_PARITY_EN
        line[9]  = (^d) ^ par_flip;
        line[10] = stop_bit;
`else
        line[9] = stop_bit;
`endif
        n = 0;
        start_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (n == max_cyc) return;
                rx_in = line[i];
                n = n + 1;
                @(negedge clk);
            end
        end
    endtask

    int s0, s1, b_done, b_ferr, b_perr;

    initial begin
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_done", rx_done, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_parity_err", parity_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);

        // single frame
        b_done = done_cnt; b_ferr = ferr_cnt;
        send_frame(8'hA1, 1'b1, 1'b0, 1000, s0);
        idle(5);
        chk("t1_done_cnt", done_cnt - b_done, 1);
        chk("t1_data", d_data[b_done], 8'hA1);
        chk("t1_rx_data", rx_data, 8'hA1);
        chk("t1_ferr", ferr_cnt - b_ferr, 0);
        chk("t1_latency", d_cyc[b_done] - s0, LAT);

        // back-to-back frames
        b_done = done_cnt;
        send_frame(8'hB1, 1'b1, 1'b0, 1000, s0);
        send_frame(8'h55, 1'b1, 1'b0, 1000, s1);
        idle(5);
        chk("t2_done_cnt", done_cnt - b_done, 2);
        chk("t2_first", d_data[b_done], 8'hB1);
        chk("t2_second", d_data[b_done + 1], 8'h55);
        chk("t2_spacing", d_cyc[b_done + 1] - d_cyc[b_done], NBITS * CPB);

        // 3-clock low glitch
        b_done = done_cnt; b_ferr = ferr_cnt; b_perr = perr_cnt;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        chk("t3_pulses", (done_cnt - b_done) + (ferr_cnt - b_ferr) + (perr_cnt - b_perr), 0);
        chk("t3_busy", busy, 1'b0);
        chk("t3_rx_data", rx_data, 8'h55);

        // stop bit low, then line held low
        b_done = done_cnt; b_ferr = ferr_cnt;
        send_frame(8'hC1, 1'b0, 1'b0, 1000, s0);
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        chk("t4_ferr", ferr_cnt - b_ferr, 1);
        chk("t4_done", done_cnt - b_done, 0);
        chk("t4_rx_data", rx_data, 8'h55);
        chk("t4_busy_low", busy, 1'b1);
        idle(5);
        chk("t4_busy_rel", busy, 1'b0);

        // reset during bit 4, then a clean frame
        b_done = done_cnt; b_ferr = ferr_cnt; b_perr = perr_cnt;
        send_frame(8'hA2, 1'b1, 1'b0, 5 * CPB + CPB / 2, s0);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        chk("t5_busy_rst", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        chk("t5_abort_pulses", (done_cnt - b_done) + (ferr_cnt - b_ferr) + (perr_cnt - b_perr), 0);
        chk("t5_rx_data_rst", rx_data, 8'h00);
        send_frame(8'hA2, 1'b1, 1'b0, 1000, s0);
        idle(5);
        chk("t5_done_cnt", done_cnt - b_done, 1);
        chk("t5_rx_data", rx_data, 8'hA2);

`ifdef UART_RX_PARITY_EN
        // wrong parity, then correct parity
        b_done = done_cnt; b_perr = perr_cnt; b_ferr = ferr_cnt;
        send_frame(8'h03, 1'b1, 1'b1, 1000, s0);
        idle(5);
        chk("t6_perr", perr_cnt - b_perr, 1);
        chk("t6_no_done", done_cnt - b_done, 0);
        chk("t6_no_ferr", ferr_cnt - b_ferr, 0);
        chk("t6_rx_data_kept", rx_data, 8'hA2);
        send_frame(8'h03, 1'b1, 1'b0, 1000, s0);
        idle(5);
        chk("t6_done", done_cnt - b_done, 1);
        chk("t6_rx_data", rx_data, 8'h03);
`else
        chk("t6_perr_tied", perr_cnt, 0);
`endif

        chk("pulse_exclusive", ovl_cnt, 0);
        chk("pulse_width", long_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
